// File: rtl/branch_predict_resolve_unit_if.sv
// Pipeline-side bundle for the branch predict/resolve unit: IF lookup,
// EX resolution inputs, and flush/statistics outputs.
interface branch_predict_resolve_unit_if #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned STAT_WIDTH = 32
);
  logic [PC_WIDTH-1:0]   if_pc;
  logic                  if_is_branch;
  logic                  if_pred_taken;
  logic                  ex_valid;
  logic                  ex_branch;
  logic                  ex_jump;
  logic [2:0]            ex_funct3;
  logic                  zf;
  logic                  sf;
  logic                  vf;
  logic                  cf;
  logic [PC_WIDTH-1:0]   ex_pc;
  logic [PC_WIDTH-1:0]   ex_target;
  logic                  ex_pred_taken;
  logic                  ex_taken;
  logic                  mispredict;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic [STAT_WIDTH-1:0] branch_count;
  logic [STAT_WIDTH-1:0] mispredict_count;

  modport master (
    output if_pc, if_is_branch, ex_valid, ex_branch, ex_jump, ex_funct3,
           zf, sf, vf, cf, ex_pc, ex_target, ex_pred_taken,
    input  if_pred_taken, ex_taken, mispredict, redirect_pc,
           branch_count, mispredict_count
  );

  modport slave (
    input  if_pc, if_is_branch, ex_valid, ex_branch, ex_jump, ex_funct3,
           zf, sf, vf, cf, ex_pc, ex_target, ex_pred_taken,
    output if_pred_taken, ex_taken, mispredict, redirect_pc,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predict_resolve_unit.sv
// BHT-based direction predictor in IF plus EX-stage branch/jump resolution,
// mispredict detection and saturating statistics.
module branch_predict_resolve_unit #(
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned BHT_ENTRIES  = 64,
  parameter int unsigned INDEX_BITS   = $clog2(BHT_ENTRIES),
  parameter logic [1:0]  COUNTER_INIT = 2'b01,
  parameter int unsigned STAT_WIDTH   = 32
) (
  input logic clk,
  input logic rst,
  branch_predict_resolve_unit_if.slave bus
);

  logic [1:0]            r_bht [BHT_ENTRIES];
  logic [STAT_WIDTH-1:0] r_branch_count;
  logic [STAT_WIDTH-1:0] r_mispredict_count;

  logic [INDEX_BITS-1:0] w_if_idx;
  logic [INDEX_BITS-1:0] w_ex_idx;
  logic                  w_cond;
  logic                  w_legal;
  logic                  w_taken;
  logic                  w_mispredict;
  logic                  w_update;
  logic [1:0]            w_ex_ctr;
  logic [1:0]            w_ex_ctr_next;

  assign w_if_idx = bus.if_pc[INDEX_BITS+1:2];
  assign w_ex_idx = bus.ex_pc[INDEX_BITS+1:2];

  always_comb begin
    w_cond  = 1'b0;
    w_legal = 1'b1;
    case (bus.ex_funct3)
      3'b000:  w_cond = bus.zf;
      3'b001:  w_cond = ~bus.zf;
      3'b100:  w_cond = bus.sf != bus.vf;
      3'b101:  w_cond = bus.sf == bus.vf;
      3'b110:  w_cond = ~bus.cf;
      3'b111:  w_cond = bus.cf;
      default: w_legal = 1'b0;
    endcase
  end

  // Branch decode takes priority when both ex_branch and ex_jump are set.
  always_comb begin
    w_taken = 1'b0;
    if (bus.ex_valid) begin
      if (bus.ex_branch)    w_taken = w_cond & w_legal;
      else if (bus.ex_jump) w_taken = 1'b1;
    end
  end

  assign w_mispredict = bus.ex_valid & (bus.ex_branch | bus.ex_jump) &
                        (w_taken != bus.ex_pred_taken);
  assign w_update     = bus.ex_valid & bus.ex_branch & w_legal;

  assign w_ex_ctr = r_bht[w_ex_idx];

  always_comb begin
    w_ex_ctr_next = w_ex_ctr;
    if (w_taken) begin
      if (w_ex_ctr != 2'b11) w_ex_ctr_next = w_ex_ctr + 2'b01;
    end else begin
      if (w_ex_ctr != 2'b00) w_ex_ctr_next = w_ex_ctr - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) r_bht[i] <= COUNTER_INIT;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_update) r_bht[w_ex_idx] <= w_ex_ctr_next;
      if (w_update && r_branch_count != '1) r_branch_count <= r_branch_count + 1'b1;
      if (w_mispredict && r_mispredict_count != '1) begin
        r_mispredict_count <= r_mispredict_count + 1'b1;
      end
    end
  end

  // No write bypass: a same-cycle update becomes visible to IF next cycle.
  assign bus.if_pred_taken    = bus.if_is_branch & r_bht[w_if_idx][1];
  assign bus.ex_taken         = w_taken;
  assign bus.mispredict       = w_mispredict;
  assign bus.redirect_pc      = w_taken ? bus.ex_target : bus.ex_pc + PC_WIDTH'(4);
  assign bus.branch_count     = r_branch_count;
  assign bus.mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// Directed bench for branch_predict_resolve_unit; a second instance with
// 4-bit statistics shares the stimulus to exercise counter saturation.
module tb_branch_predict_resolve_unit;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  branch_predict_resolve_unit_if #(.PC_WIDTH(32), .STAT_WIDTH(32)) bus ();
  branch_predict_resolve_unit_if #(.PC_WIDTH(32), .STAT_WIDTH(4))  bus4 ();

  branch_predict_resolve_unit #(.STAT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  branch_predict_resolve_unit #(.STAT_WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  assign bus4.if_pc         = bus.if_pc;
  assign bus4.if_is_branch  = bus.if_is_branch;
  assign bus4.ex_valid      = bus.ex_valid;
  assign bus4.ex_branch     = bus.ex_branch;
  assign bus4.ex_jump       = bus.ex_jump;
  assign bus4.ex_funct3     = bus.ex_funct3;
  assign bus4.zf            = bus.zf;
  assign bus4.sf            = bus.sf;
  assign bus4.vf            = bus.vf;
  assign bus4.cf            = bus.cf;
  assign bus4.ex_pc         = bus.ex_pc;
  assign bus4.ex_target     = bus.ex_target;
  assign bus4.ex_pred_taken = bus.ex_pred_taken;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change #1 after the edge; combinational outputs are checked before the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    bus.ex_valid = 1'b0; bus.ex_branch = 1'b0; bus.ex_jump = 1'b0;
    bus.ex_funct3 = 3'b000; bus.zf = 1'b0; bus.sf = 1'b0; bus.vf = 1'b0; bus.cf = 1'b0;
    bus.ex_pc = '0; bus.ex_target = '0; bus.ex_pred_taken = 1'b0;
  endtask

  task automatic ex_br(input logic [2:0] f3, input logic z, input logic s, input logic v,
                       input logic c, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pred);
    bus.ex_valid = 1'b1; bus.ex_branch = 1'b1; bus.ex_jump = 1'b0;
    bus.ex_funct3 = f3; bus.zf = z; bus.sf = s; bus.vf = v; bus.cf = c;
    bus.ex_pc = pc; bus.ex_target = tgt; bus.ex_pred_taken = pred;
  endtask

  task automatic ex_jal(input logic [31:0] pc, input logic [31:0] tgt);
    ex_idle();
    bus.ex_valid = 1'b1; bus.ex_jump = 1'b1;
    bus.ex_pc = pc; bus.ex_target = tgt;
  endtask

  task automatic probe(input string tag, input logic [31:0] pc, input logic exp);
    bus.if_pc = pc;
    #1;
    check(tag, 64'(bus.if_pred_taken), 64'(exp));
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    bus.if_pc = 32'h100;
    bus.if_is_branch = 1'b1;
    ex_idle();
    step();
    step();
    rst = 1'b0;
    #1;

    check("reset_pred", 64'(bus.if_pred_taken), 64'd0);
    check("reset_bcnt", 64'(bus.branch_count), 64'd0);
    check("reset_mcnt", 64'(bus.mispredict_count), 64'd0);
    check("idle_taken", 64'(bus.ex_taken), 64'd0);
    check("idle_misp", 64'(bus.mispredict), 64'd0);
    bus.if_is_branch = 1'b0;
    #1;
    check("no_branch_pred", 64'(bus.if_pred_taken), 64'd0);
    bus.if_is_branch = 1'b1;

    // Two taken BEQ at 0x100: 01 -> 10 -> 11.
    ex_br(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h400, 1'b0);
    #1;
    check("beq1_taken", 64'(bus.ex_taken), 64'd1);
    check("beq1_misp", 64'(bus.mispredict), 64'd1);
    check("beq1_redir", 64'(bus.redirect_pc), 64'h400);
    step();
    check("beq1_trained", 64'(bus.if_pred_taken), 64'd1);
    ex_br(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h400, 1'b1);
    #1;
    check("beq2_misp", 64'(bus.mispredict), 64'd0);
    step();
    ex_idle();
    check("beq_bcnt", 64'(bus.branch_count), 64'd2);
    check("beq_mcnt", 64'(bus.mispredict_count), 64'd1);
    probe("pred_0x100", 32'h100, 1'b1);
    probe("pred_alias", 32'h200, 1'b1);
    probe("pred_0x104", 32'h104, 1'b0);

    // BLT sf!=vf predicted taken: correct; 0x104 01 -> 10.
    ex_br(3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h104, 32'h500, 1'b1);
    #1;
    check("blt_taken", 64'(bus.ex_taken), 64'd1);
    check("blt_misp", 64'(bus.mispredict), 64'd0);
    step();
    // BGEU with cf=0: not taken, predicted taken -> fall-through redirect.
    ex_br(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h108, 32'h600, 1'b1);
    #1;
    check("bgeu_taken", 64'(bus.ex_taken), 64'd0);
    check("bgeu_misp", 64'(bus.mispredict), 64'd1);
    check("bgeu_redir", 64'(bus.redirect_pc), 64'h10c);
    step();
    // Illegal funct3 at 0x100 with zf=1: no direction, no training, no count.
    ex_br(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h700, 1'b0);
    #1;
    check("ill_taken", 64'(bus.ex_taken), 64'd0);
    check("ill_misp", 64'(bus.mispredict), 64'd0);
    step();
    ex_idle();
    check("ill_bcnt", 64'(bus.branch_count), 64'd4);
    probe("ill_pred_0x100", 32'h100, 1'b1);

    // JAL at 0x104 (entry 10) must not train it.
    ex_jal(32'h104, 32'h800);
    #1;
    check("jal_taken", 64'(bus.ex_taken), 64'd1);
    check("jal_misp", 64'(bus.mispredict), 64'd1);
    check("jal_redir", 64'(bus.redirect_pc), 64'h800);
    step();
    check("jal_bcnt", 64'(bus.branch_count), 64'd4);
    check("jal_mcnt", 64'(bus.mispredict_count), 64'd3);
    // One not-taken BNE at 0x104: 10 -> 01 only if the JAL left it untouched.
    ex_br(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h104, 32'h900, 1'b0);
    step();
    ex_idle();
    probe("jal_no_train", 32'h104, 1'b0);

    // Same-index read/write at 0x108 (entry 00): taken -> 01, taken -> 10.
    bus.if_pc = 32'h108;
    ex_br(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h108, 32'ha00, 1'b1);
    step();
    ex_br(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h108, 32'ha00, 1'b1);
    #1;
    check("rw_same_cycle", 64'(bus.if_pred_taken), 64'd0);
    step();
    ex_idle();
    #1;
    check("rw_next_cycle", 64'(bus.if_pred_taken), 64'd1);

    // Saturation at 0x10c: five not-taken -> 00, one taken -> 01.
    for (int i = 0; i < 5; i++) begin
      ex_br(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10c, 32'hb00, 1'b0);
      step();
    end
    ex_br(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10c, 32'hb00, 1'b0);
    step();
    ex_idle();
    probe("sat_pred", 32'h10c, 1'b0);
    check("sat_bcnt", 64'(bus.branch_count), 64'd13);
    check("sat_mcnt", 64'(bus.mispredict_count), 64'd4);

    // 20 more mispredicting jumps saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      ex_jal(32'h300, 32'hc00);
      step();
    end
    ex_idle();
    #1;
    check("stat4_mcnt", 64'(bus4.mispredict_count), 64'd15);
    check("stat4_bcnt", 64'(bus4.branch_count), 64'd13);
    check("stat32_mcnt", 64'(bus.mispredict_count), 64'd24);

    // Reset wins over a same-cycle taken update at 0x10c (entry 01).
    ex_br(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10c, 32'hd00, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ex_idle();
    probe("rst_win_pred", 32'h10c, 1'b0);
    probe("rst_pred_0x100", 32'h100, 1'b0);
    check("rst_bcnt", 64'(bus.branch_count), 64'd0);
    check("rst_mcnt", 64'(bus.mispredict_count), 64'd0);
    check("rst_mcnt4", 64'(bus4.mispredict_count), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predict_resolve_unit.md
Name: branch_predict_resolve_unit

Overview:
Parametrised successor to the single-cycle branch decision logic. It combines a PC-indexed branch history table (BHT) of 2-bit saturating counters, used to predict direction in IF, with EX-stage resolution of BEQ/BNE/BLT/BGE/BLTU/BGEU and jumps from ALU flags. It compares the resolved outcome with the carried prediction and raises mispredict/redirect to the hazard/flush logic. It also keeps saturating branch and mispredict statistics counters.

Parameters:
PC_WIDTH, 32, width of PC and target buses
BHT_ENTRIES, 64, number of 2-bit counters; power of two, >= 2
INDEX_BITS, $clog2(BHT_ENTRIES), derived; not overridden
COUNTER_INIT, 2'b01, reset value of every BHT entry (weakly not-taken)
STAT_WIDTH, 32, width of statistics counters

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
if_pc  in  PC_WIDTH  fetch PC
if_is_branch  in  1  pre-decoded conditional branch in IF
if_pred_taken  out  1  predicted direction
ex_valid  in  1  EX holds a valid, non-stalled instruction
ex_branch  in  1  EX instruction is a conditional branch
ex_jump  in  1  EX instruction is JAL/JALR
ex_funct3  in  3  branch funct3
zf, sf, vf, cf  in  1 each  ALU flags from rs1-rs2 subtraction
ex_pc  in  PC_WIDTH  PC of EX instruction
ex_target  in  PC_WIDTH  computed branch/jump target
ex_pred_taken  in  1  prediction carried down the pipeline
ex_taken  out  1  resolved direction
mispredict  out  1  flush request
redirect_pc  out  PC_WIDTH  correct next PC when mispredict=1
branch_count  out  STAT_WIDTH  resolved conditional branches
mispredict_count  out  STAT_WIDTH  mispredictions (branches and jumps)

Behaviour:
- Clock clk, reset rst: synchronous, active-high. On rst all BHT entries <= COUNTER_INIT; branch_count, mispredict_count <= 0. rst overrides any same-cycle update.
- Index = pc[INDEX_BITS+1:2] for both lookup and update (bits [1:0] ignored).
- Prediction (combinational): if_pred_taken = if_is_branch & BHT[idx(if_pc)][1]; 0 when if_is_branch=0.
- Resolution (combinational, gated by ex_valid; all outputs 0 when ex_valid=0):
  - branch: 000 taken=zf; 001 ~zf; 100 sf!=vf; 101 sf==vf; 110 ~cf; 111 cf; 010/011 illegal -> taken=0.
  - jump (ex_branch=0): taken=1. ex_branch and ex_jump both 1: branch decode wins.
  - neither: taken=0, mispredict=0.
- mispredict = ex_valid & (ex_branch|ex_jump) & (ex_taken != ex_pred_taken). Jumps are never predicted by the BHT; with ex_pred_taken=0 every jump mispredicts.
- redirect_pc = ex_taken ? ex_target : ex_pc + 4 (mod 2^PC_WIDTH); value is don't-care when mispredict=0.
- BHT update at clock edge when ex_valid & ex_branch & legal funct3: taken -> counter+1 saturating at 11; not-taken -> counter-1 saturating at 00. Jumps and illegal funct3 do not update.
- Same-cycle IF read and EX write to the same index: IF sees the old value (no bypass); the new value is visible next cycle.
- Statistics: branch_count += 1 per legal resolved branch; mispredict_count += 1 per mispredict. Both saturate at all-ones and never wrap.
- No other state; latency: prediction 0 cycles, resolution 0 cycles, training visible 1 cycle after the update edge.

Test Plan:
- Reset, if_pc=0x100, if_is_branch=1 -> if_pred_taken=0 (entry 01); counters 0.
- Two taken BEQ (zf=1) at ex_pc=0x100 with ex_pred_taken=0 -> first: mispredict=1, redirect_pc=ex_target. Afterwards entry=11 and if_pred_taken=1 at 0x100; aliased 0x100+4*BHT_ENTRIES also predicts 1; 0x104 still 0.
- BLT sf=1,vf=0 pred 1 -> taken=1, mispredict=0. BGEU cf=0 pred 1 -> mispredict=1, redirect_pc=ex_pc+4. funct3=010 -> taken=0, no BHT/count change.
- JAL, ex_pred_taken=0 -> ex_taken=1, mispredict=1, redirect_pc=ex_target, BHT unchanged, branch_count unchanged, mispredict_count+1.
- Same-index read/write: IF lookup in the update cycle returns the pre-update bit; the next cycle returns the updated bit. Saturation: 5 not-taken -> entry 00, then 1 taken -> 01, still predicts 0.
- STAT_WIDTH=4: 20 mispredicts -> mispredict_count holds 15. rst asserted together with a taken update -> entry 01, counters 0.
